// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// grant identifiers and default bus widths.
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUS_IF = 2'd1,
      BUS_DM = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   // Identity of the side that last owned the bus (round-robin pointer).
   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Bus-ack watchdog for the memory port arbiter.
//   clock, reset : clock, async active-low reset
//   clear        : synchronous clear (held while no transaction is active)
//   enable       : count this cycle (transaction active, no ack)
//   limit        : number of unacknowledged cycles allowed
//   expired      : this enabled cycle is the limit-th one without ack
import mem_port_arbiter_pkg::*;

module mem_timeout_counter #(
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   input  logic [CW-1:0] limit,
   output logic          expired
);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + CW'(1);
   end

   // Flag on the cycle that would bring the count up to the limit, so the
   // bus request is held for exactly 'limit' cycles before aborting.
   assign expired = enable && (count == limit - CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external memory bus between instruction fetch and data memory.
// One request/ack bus transaction per grant, round-robin on ties, and a
// one-cycle ready pulse (plus captured read data) back to the granted side.
//   clock, reset          : clock, async active-low reset
//   io_if_*               : fetch requester (req/addr in, rdata/rdy out)
//   io_dm_*, io_DataMem_rdy : data requester (rd/wr/addr/wdata/wmask in)
//   io_bus_*              : external bus (req/we/addr/wdata/wmask out, ack/rdata in)
//   io_timeout            : pulses with the ready pulse when an access aborted
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                io_if_req,
   input  logic [ADDR_W-1:0]   io_if_addr,
   output logic [DATA_W-1:0]   io_if_rdata,
   output logic                io_if_rdy,
   input  logic                io_dm_rd,
   input  logic                io_dm_wr,
   input  logic [ADDR_W-1:0]   io_dm_addr,
   input  logic [DATA_W-1:0]   io_dm_wdata,
   input  logic [DATA_W/8-1:0] io_dm_wmask,
   output logic [DATA_W-1:0]   io_dm_rdata,
   output logic                io_DataMem_rdy,
   output logic                io_bus_req,
   output logic                io_bus_we,
   output logic [ADDR_W-1:0]   io_bus_addr,
   output logic [DATA_W-1:0]   io_bus_wdata,
   output logic [DATA_W/8-1:0] io_bus_wmask,
   input  logic                io_bus_ack,
   input  logic [DATA_W-1:0]   io_bus_rdata,
   output logic                io_timeout
);

   localparam int            CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   arb_state_e state;
   logic       last_grant;
   logic       dm_req, grant_dm, in_bus, cnt_en, expired;

   assign dm_req   = io_dm_rd | io_dm_wr;
   // Data wins when alone, or on a tie if fetch had the bus last.
   assign grant_dm = dm_req && (!io_if_req || (last_grant == GRANT_IF));
   assign in_bus   = (state == BUS_IF) || (state == BUS_DM);
   assign cnt_en   = in_bus && !io_bus_ack;

   mem_timeout_counter #(.CW(CW)) u_tmo (
      .clock   (clock),
      .reset   (reset),
      .clear   (!in_bus),
      .enable  (cnt_en),
      .limit   (LIMIT),
      .expired (expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         last_grant     <= GRANT_IF;
         io_bus_req     <= 1'b0;
         io_bus_we      <= 1'b0;
         io_bus_addr    <= '0;
         io_bus_wdata   <= '0;
         io_bus_wmask   <= '0;
         io_if_rdata    <= '0;
         io_dm_rdata    <= '0;
         io_if_rdy      <= 1'b0;
         io_DataMem_rdy <= 1'b0;
         io_timeout     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dm_req || io_if_req) begin
                  io_bus_req <= 1'b1;
                  if (grant_dm) begin
                     state        <= BUS_DM;
                     last_grant   <= GRANT_DM;
                     // rd+wr together is a write
                     io_bus_we    <= io_dm_wr;
                     io_bus_addr  <= io_dm_addr;
                     io_bus_wdata <= io_dm_wdata;
                     io_bus_wmask <= io_dm_wr ? io_dm_wmask : '1;
                  end else begin
                     state        <= BUS_IF;
                     last_grant   <= GRANT_IF;
                     io_bus_we    <= 1'b0;
                     io_bus_addr  <= io_if_addr;
                     io_bus_wdata <= '0;
                     io_bus_wmask <= '1;
                  end
               end
            end
            BUS_IF, BUS_DM: begin
               // Ack takes priority over a coincident expiry.
               if (io_bus_ack || expired) begin
                  io_bus_req     <= 1'b0;
                  state          <= RESP;
                  io_if_rdy      <= (state == BUS_IF);
                  io_DataMem_rdy <= (state == BUS_DM);
                  io_timeout     <= !io_bus_ack;
                  if (!io_bus_ack) begin
                     if (state == BUS_IF) io_if_rdata <= '0;
                     else                 io_dm_rdata <= '0;
                  end else if (!io_bus_we) begin
                     if (state == BUS_IF) io_if_rdata <= io_bus_rdata;
                     else                 io_dm_rdata <= io_bus_rdata;
                  end
               end
            end
            RESP: begin
               io_if_rdy      <= 1'b0;
               io_DataMem_rdy <= 1'b0;
               io_timeout     <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
